// File: rtl/impl_monitor_pkg.sv
// Shared types and helpers for the implication monitor: window-FSM states,
// delay type, wildcard compare and saturating increment.
package impl_monitor_pkg;

    localparam int MAX_DLY_DEF = 7;
    localparam int DLY_W_DEF   = $clog2(MAX_DLY_DEF + 1);

    typedef logic [DLY_W_DEF-1:0] dly_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } win_state_e;

    // Operands are zero-extended by the caller; widths up to 64 bits supported.
    function automatic logic wild_match(input logic [63:0] d,
                                        input logic [63:0] p,
                                        input logic [63:0] m);
        return ((d ^ p) & m) == 64'd0;
    endfunction

    // Saturating increment of a w-bit counter carried in a 32-bit container.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int w);
        logic [31:0] top_v;
        top_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (cnt == top_v) ? cnt : cnt + 32'd1;
    endfunction

endpackage

// File: rtl/impl_monitor_ch.sv
// One checker channel: exact-delay pending shift register, window FSM,
// registered pass/fail pulses, saturating counters and sticky error.
module impl_monitor_ch
    import impl_monitor_pkg::*;
#(
    parameter int DW      = 8,
    parameter int MAX_DLY = 7,
    parameter int CNT_W   = 16,
    localparam int DLY_W  = $clog2(MAX_DLY + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DLY_W-1:0] cfg_dly,
    input  logic             cfg_win,
    input  logic             ante,
    input  logic [DW-1:0]    data,
    input  logic [DW-1:0]    pat,
    input  logic [DW-1:0]    mask,
    output logic             fail,
    output logic             pass,
    output logic             err,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy
);

    logic [DLY_W-1:0]   k_in;
    logic               match;
    logic               is_exact;
    logic               acc_exact;
    logic               acc_win;
    logic               ex_res;
    logic               win_pass;
    logic               win_fail;

    logic [MAX_DLY-1:0] pend_q, pend_d;
    logic               pass_q, pass_d;
    logic               fail_q, fail_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0]   fail_cnt_q, fail_cnt_d;

    win_state_e         state_q;
    logic [DLY_W-1:0]   cnt_q;
    logic [DLY_W-1:0]   k_q;

    always_comb begin
        k_in      = (cfg_dly > DLY_W'(MAX_DLY)) ? DLY_W'(MAX_DLY) : cfg_dly;
        match     = wild_match(64'(data), 64'(pat), 64'(mask));
        // Window mode with k=0 degenerates to the overlapping exact check.
        is_exact  = !cfg_win || (k_in == '0);
        acc_exact = en && ante && is_exact;
        acc_win   = en && ante && !is_exact && (state_q == ST_IDLE);
        ex_res    = (acc_exact && (k_in == '0)) || pend_q[0];
        win_pass  = (state_q == ST_WAIT) && match;
        win_fail  = (state_q == ST_WAIT) && !match && (cnt_q == k_q);
    end

    // Entries are inserted at slot k-1 so they reach slot 0 exactly k cycles later.
    always_comb begin
        pend_d = pend_q >> 1;
        for (int j = 0; j < MAX_DLY; j++) begin
            if (acc_exact && (k_in == DLY_W'(j + 1))) begin
                pend_d[j] = 1'b1;
            end
        end
        pass_d     = (ex_res && match)  || win_pass;
        fail_d     = (ex_res && !match) || win_fail;
        pass_cnt_d = pass_d ? CNT_W'(sat_inc(32'(pass_cnt_q), CNT_W)) : pass_cnt_q;
        fail_cnt_d = fail_d ? CNT_W'(sat_inc(32'(fail_cnt_q), CNT_W)) : fail_cnt_q;
        err_d      = err_q || fail_d;
        if (clr) begin
            pend_d     = '0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
            pass_cnt_d = '0;
            fail_cnt_d = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= '0;
            pass_q     <= 1'b0;
            fail_q     <= 1'b0;
            err_q      <= 1'b0;
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
        end else begin
            pend_q     <= pend_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            err_q      <= err_d;
            pass_cnt_q <= pass_cnt_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
        end else if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            k_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (acc_win) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= DLY_W'(1);
                        k_q     <= k_in;
                    end
                end
                ST_WAIT: begin
                    if (match || (cnt_q == k_q)) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q + DLY_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pass     = pass_q;
    assign fail     = fail_q;
    assign err      = err_q;
    assign pass_cnt = pass_cnt_q;
    assign fail_cnt = fail_cnt_q;
    assign busy     = (|pend_q) || (state_q == ST_WAIT);

endmodule

// File: rtl/impl_monitor.sv
// N-channel runtime implication checker; each channel is an independent
// impl_monitor_ch, with the sticky errors ORed into a single err.
module impl_monitor
    import impl_monitor_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int MAX_DLY = MAX_DLY_DEF,
    parameter int CNT_W   = 16,
    localparam int DLY_W  = $clog2(MAX_DLY + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic [NCH*DLY_W-1:0] cfg_dly,
    input  logic [NCH-1:0]       cfg_win,
    input  logic [NCH-1:0]       ante,
    input  logic [NCH*DW-1:0]    data,
    input  logic [NCH*DW-1:0]    pat,
    input  logic [NCH*DW-1:0]    mask,
    output logic [NCH-1:0]       fail,
    output logic [NCH-1:0]       pass,
    output logic                 err,
    output logic [NCH*CNT_W-1:0] pass_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt,
    output logic [NCH-1:0]       busy
);

    logic [NCH-1:0] ch_err;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            impl_monitor_ch #(
                .DW      (DW),
                .MAX_DLY (MAX_DLY),
                .CNT_W   (CNT_W)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .en       (en),
                .clr      (clr),
                .cfg_dly  (cfg_dly[gi*DLY_W +: DLY_W]),
                .cfg_win  (cfg_win[gi]),
                .ante     (ante[gi]),
                .data     (data[gi*DW +: DW]),
                .pat      (pat[gi*DW +: DW]),
                .mask     (mask[gi*DW +: DW]),
                .fail     (fail[gi]),
                .pass     (pass[gi]),
                .err      (ch_err[gi]),
                .pass_cnt (pass_cnt[gi*CNT_W +: CNT_W]),
                .fail_cnt (fail_cnt[gi*CNT_W +: CNT_W]),
                .busy     (busy[gi])
            );
        end
    endgenerate

    assign err = |ch_err;

endmodule

// File: tb/tb_impl_monitor.sv
// Scoreboard bench for impl_monitor: expected pulses are queued as stimulus
// is driven and matched against pass/fail pulses on the falling edge.
module tb_impl_monitor;
    import impl_monitor_pkg::*;

    localparam int NCH     = 4;
    localparam int DW      = 8;
    localparam int MAX_DLY = 7;
    localparam int CNT_W   = 4;
    localparam int DLY_W   = $clog2(MAX_DLY + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 en;
    logic                 clr;
    logic [NCH*DLY_W-1:0] cfg_dly;
    logic [NCH-1:0]       cfg_win;
    logic [NCH-1:0]       ante;
    logic [NCH*DW-1:0]    data;
    logic [NCH*DW-1:0]    pat;
    logic [NCH*DW-1:0]    mask;
    logic [NCH-1:0]       fail;
    logic [NCH-1:0]       pass;
    logic                 err;
    logic [NCH*CNT_W-1:0] pass_cnt;
    logic [NCH*CNT_W-1:0] fail_cnt;
    logic [NCH-1:0]       busy;

    dly_t       k_a   [NCH];
    logic       w_a   [NCH];
    logic       an_a  [NCH];
    logic [7:0] d_a   [NCH];
    logic [7:0] p_a   [NCH];
    logic [7:0] m_a   [NCH];

    typedef struct {
        int cyc;
        int ch;
        bit is_pass;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   c0;

    impl_monitor #(
        .NCH     (NCH),
        .DW      (DW),
        .MAX_DLY (MAX_DLY),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clr      (clr),
        .cfg_dly  (cfg_dly),
        .cfg_win  (cfg_win),
        .ante     (ante),
        .data     (data),
        .pat      (pat),
        .mask     (mask),
        .fail     (fail),
        .pass     (pass),
        .err      (err),
        .pass_cnt (pass_cnt),
        .fail_cnt (fail_cnt),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        cfg_dly = '0;
        cfg_win = '0;
        ante    = '0;
        data    = '0;
        pat     = '0;
        mask    = '0;
        for (int i = 0; i < NCH; i++) begin
            cfg_dly[i*DLY_W +: DLY_W] = k_a[i];
            cfg_win[i]                = w_a[i];
            ante[i]                   = an_a[i];
            data[i*DW +: DW]          = d_a[i];
            pat[i*DW +: DW]           = p_a[i];
            mask[i*DW +: DW]          = m_a[i];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end else begin
            $display("[TB] ok %s = %0h (cycle %0d)", tag, obs, cyc);
        end
    endtask

    task automatic expect_pulse(input int at, input int ch, input bit p);
        exp_t e;
        e.cyc     = at;
        e.ch      = ch;
        e.is_pass = p;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] pcnt(input int ch);
        return pass_cnt[ch*CNT_W +: CNT_W];
    endfunction

    function automatic logic [CNT_W-1:0] fcnt(input int ch);
        return fail_cnt[ch*CNT_W +: CNT_W];
    endfunction

    // Pulses are encoded as cycle*16 + ch*2 + is_pass for a single compare.
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("pulse_missed", 32'(cyc), 32'(sb[0].cyc));
                void'(sb.pop_front());
            end
            for (int ch = 0; ch < NCH; ch++) begin
                for (int k = 0; k < 2; k++) begin
                    if ((k == 1) ? pass[ch] : fail[ch]) begin
                        if (sb.size() == 0) begin
                            check("pulse_unexp", 32'(cyc*16 + ch*2 + k), 32'hFFFF_FFFF);
                        end else begin
                            check("pulse", 32'(cyc*16 + ch*2 + k),
                                  32'(sb[0].cyc*16 + sb[0].ch*2 + int'(sb[0].is_pass)));
                            void'(sb.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        en  = 1'b0;
        clr = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            an_a[i] = 1'b0;
            d_a[i]  = 8'h00;
        end
        k_a[0] = 3'd0; w_a[0] = 1'b0; p_a[0] = 8'hA5; m_a[0] = 8'hFF;
        k_a[1] = 3'd3; w_a[1] = 1'b0; p_a[1] = 8'h5A; m_a[1] = 8'hFF;
        k_a[2] = 3'd4; w_a[2] = 1'b1; p_a[2] = 8'h30; m_a[2] = 8'hF0;
        k_a[3] = 3'd0; w_a[3] = 1'b0; p_a[3] = 8'h00; m_a[3] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("rst_pass", 32'(pass), 0);
        check("rst_fail", 32'(fail), 0);
        check("rst_err", 32'(err), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pass_cnt", 32'(pass_cnt), 0);
        check("rst_fail_cnt", 32'(fail_cnt), 0);
        rst = 1'b0;
        en  = 1'b1;

        // Overlapping check on ch0, then a blocked antecedent with en=0.
        step();
        an_a[0] = 1'b1; d_a[0] = 8'hA5; expect_pulse(cyc + 1, 0, 1'b1);
        step();
        d_a[0] = 8'hA4; expect_pulse(cyc + 1, 0, 1'b0);
        step();
        en = 1'b0;
        step();
        an_a[0] = 1'b0; en = 1'b1;
        check("k0_pass_cnt0", 32'(pcnt(0)), 1);
        check("k0_fail_cnt0", 32'(fcnt(0)), 1);
        check("k0_err", 32'(err), 1);

        // Exact k=3 on ch1, three back-to-back antecedents.
        step();
        an_a[1] = 1'b1; d_a[1] = 8'h00; c0 = cyc;
        expect_pulse(c0 + 4, 1, 1'b0);
        expect_pulse(c0 + 5, 1, 1'b1);
        expect_pulse(c0 + 6, 1, 1'b0);
        step();
        step();
        step();
        an_a[1] = 1'b0;
        step();
        d_a[1] = 8'h5A;
        step();
        d_a[1] = 8'h00;
        check("k3_busy_pending", 32'(busy[1]), 1);
        step();
        check("k3_busy_done", 32'(busy[1]), 0);
        check("k3_pass_cnt1", 32'(pcnt(1)), 1);
        check("k3_fail_cnt1", 32'(fcnt(1)), 2);

        // Window k=4 on ch2: masked match at +2, then a timeout with a re-ante.
        step();
        an_a[2] = 1'b1; d_a[2] = 8'h00; c0 = cyc;
        expect_pulse(c0 + 3, 2, 1'b1);
        step();
        an_a[2] = 1'b0;
        step();
        d_a[2] = 8'h3F;
        step();
        d_a[2] = 8'h00;
        check("win_busy_after_pass", 32'(busy[2]), 0);
        step();
        an_a[2] = 1'b1; c0 = cyc;
        expect_pulse(c0 + 5, 2, 1'b0);
        step();
        an_a[2] = 1'b0;
        step();
        an_a[2] = 1'b1;
        step();
        an_a[2] = 1'b0;
        step();
        check("win_busy_in_window", 32'(busy[2]), 1);
        step();
        check("win_fail_cnt2", 32'(fcnt(2)), 1);
        check("win_pass_cnt2", 32'(pcnt(2)), 1);
        check("win_busy_end", 32'(busy[2]), 0);

        // Saturation: 20 always-matching antecedents on ch3.
        step();
        for (int n = 0; n < 20; n++) begin
            an_a[3] = 1'b1;
            d_a[3]  = 8'($urandom);
            expect_pulse(cyc + 1, 3, 1'b1);
            step();
        end
        an_a[3] = 1'b0;
        check("sat_pass_cnt3", 32'(pcnt(3)), 32'hF);
        check("sat_fail_cnt3", 32'(fcnt(3)), 0);

        // clr in the resolving cycle of an exact k=2 check.
        k_a[1] = 3'd2; d_a[1] = 8'h5A;
        step();
        an_a[1] = 1'b1;
        step();
        an_a[1] = 1'b0;
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_pass", 32'(pass), 0);
        check("clr_pass_cnt", 32'(pass_cnt), 0);
        check("clr_fail_cnt", 32'(fail_cnt), 0);
        check("clr_err", 32'(err), 0);
        check("clr_busy", 32'(busy), 0);

        // Reset in the middle of a window check.
        step();
        an_a[0] = 1'b1; d_a[0] = 8'hA4; expect_pulse(cyc + 1, 0, 1'b0);
        step();
        an_a[0] = 1'b0; an_a[2] = 1'b1; d_a[2] = 8'h00;
        step();
        an_a[2] = 1'b0;
        step();
        check("pre_rst_err", 32'(err), 1);
        #1 rst = 1'b1;
        #1;
        check("arst_err", 32'(err), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_fail_cnt", 32'(fail_cnt), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        an_a[2] = 1'b1; d_a[2] = 8'h00; c0 = cyc;
        expect_pulse(c0 + 2, 2, 1'b1);
        step();
        an_a[2] = 1'b0; d_a[2] = 8'h3F;
        step();
        d_a[2] = 8'h00;
        step();
        check("post_rst_pass_cnt2", 32'(pcnt(2)), 1);
        check("post_rst_busy2", 32'(busy[2]), 0);

        step();
        step();
        check("sb_empty", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/impl_monitor.md
Name: impl_monitor

Overview:
- Parametrised N-channel runtime implication checker.
- Implements, in synthesizable RTL, the temporal forms a |-> b (overlapping), a |=> b (next cycle), a ##k b (exact delay) and a ##[1:k] b (window).
- The consequent is a wildcard compare: data ==? pattern, with mask bits acting as don't-care.
- Sits beside datapath blocks as on-chip assertion hardware; per-channel pass/fail counters are read by CSR logic.

Parameters:
- NCH, 4, number of independent channels.
- DW, 8, consequent data width per channel.
- MAX_DLY, 7, largest programmable delay/window in cycles (>=1).
- CNT_W, 16, pass/fail counter width (saturating).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global enable; when 0 no new antecedents are accepted, but pending checks still resolve.
- clr  in  1  synchronous clear of counters, sticky error and all pending state.
- cfg_dly  in  NCH*$clog2(MAX_DLY+1)  per-channel delay k; 0 = overlapping. Values above MAX_DLY clamp to MAX_DLY.
- cfg_win  in  NCH  per-channel mode: 0 = exact delay k, 1 = window [1:k] (k=0 treated as exact 0).
- ante  in  NCH  antecedent strobe per channel.
- data  in  NCH*DW  consequent data per channel.
- pat  in  NCH*DW  compare pattern per channel.
- mask  in  NCH*DW  1 = bit compared, 0 = don't care.
- fail  out  NCH  one-cycle pulse on a failed check.
- pass  out  NCH  one-cycle pulse on a passed check.
- err  out  1  sticky OR of all fails since reset/clr.
- pass_cnt  out  NCH*CNT_W  saturating pass count.
- fail_cnt  out  NCH*CNT_W  saturating fail count.
- busy  out  NCH  channel has a pending check.

Behaviour:
- Reset (async, rst=1): fail, pass, err, busy, all counters and all pending state go to 0. Outputs are registered.
- match[i] = ((data[i] ^ pat[i]) & mask[i]) == 0, combinational. An all-zero mask always matches.
- Configuration is sampled at antecedent acceptance; changing cfg while busy does not affect checks already pending.
- Exact mode, k=0: the check resolves in the same cycle as ante; pass/fail is registered and appears 1 cycle after ante.
- Exact mode, k>=1:
  - Accepted antecedents enter a MAX_DLY-deep pending shift register; overlapping antecedents are all tracked (pipelined, no loss).
  - The entry accepted at cycle t is checked against match at cycle t+k; pass/fail appears at t+k+1.
- Window mode, per-channel FSM:
  - IDLE: ante & en -> WAIT with cnt=1.
  - WAIT: match -> pass, go to IDLE. Else if cnt==k -> fail, go to IDLE. Else cnt++.
  - Matching in the antecedent cycle itself does not count (window starts at 1).
  - An ante arriving while in WAIT is ignored and not counted; the window does not restart.
  - An ante in the same cycle as resolution is also ignored; IDLE is re-entered first.
- busy[i] = any pending bit set, or FSM state == WAIT.
- Counters: increment on the pass/fail pulse and saturate at all-ones; they never wrap.
- err: set on any fail; cleared only by rst or clr.
- clr has priority over everything in the same cycle. A check resolving in the clr cycle produces no pulse and no count. Pending checks are discarded.
- en=0 blocks acceptance only: the shift register keeps shifting and the FSM keeps counting.
- Reset mid-check: all pending checks are discarded with no pulse.
- Channels are fully independent; no cross-channel arbitration.

Decomposition:
- Package impl_monitor_pkg holds:
  - the window-FSM state enum (ST_IDLE, ST_WAIT);
  - a dly_t typedef of width $clog2(MAX_DLY+1);
  - a function wild_match(data, pat, mask);
  - a function sat_inc(cnt).
- Sub-module impl_monitor_ch contains one channel's shift register, FSM and counters.
- The top level does a generate over NCH, slices the vectors, and ORs the per-channel sticky errors into err.

Test Plan:
- Exact k=0, ch0, pat=8'hA5, mask=8'hFF: ante with data=A5 -> pass[0] next cycle, pass_cnt0=1. Ante with data=A4 -> fail[0], err=1.
- Exact k=3, ch1: ante on cycles 10, 11, 12, with data matching only on cycle 14 -> fail at 14, pass at 15, fail at 16. Counts pass=1, fail=2; busy low from cycle 16.
- Window k=4, ch2, mask=8'hF0, pat=8'h30: data=3F arrives 2 cycles after ante -> pass. No match over 4 cycles -> fail exactly 5 cycles after ante. A second ante inside the window is ignored, so fail_cnt=1.
- Saturation with CNT_W=4: 20 passing antecedents on ch3 -> pass_cnt3 holds 4'hF.
- clr asserted in the resolving cycle of a pending exact k=2 check -> no pulse, counters 0, err 0, busy 0 next cycle.
- Reset mid-window (rst pulsed at cnt=2) -> all outputs 0 asynchronously. A later ante starts a fresh, correct check.
